vga_text_arbiter: RTL and testbench

Arbiter that shares one single-port text RAM between the video character fetch and a host bus port. Video fetches always win and have fixed latency, so scanout never tears. Host reads and writes are queued through a small FSM and complete in the free cycles between character fetches. It sits between the text-mode video core (character address `ca`) and the 2000-entry character/attribute RAM.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_text_arbiter_if.sv | 37 +++
 rtl/vga_arb_host_fsm.sv | 112 +++++++++++
 rtl/vga_text_arbiter.sv | 75 +++++++
 tb/tb_vga_text_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the text-mode RAM arbiter.
package vga_pkg;

  localparam int TEXT_ADDR_W = 11;
  localparam int TEXT_DATA_W = 16;
  localparam int CHAR_COUNT  = 2000;

  // Field layout of one RAM word
  localparam int CHAR_LSB = 0;
  localparam int CHAR_MSB = 7;
  localparam int ATTR_LSB = 8;
  localparam int ATTR_MSB = 15;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_ISSUE = 2'd1,
    H_DATA  = 2'd2,
    H_ACK   = 2'd3
  } host_state_t;

endpackage

// File: rtl/vga_text_arbiter_if.sv
// Bus bundle for the arbiter: video fetch port, host port and text RAM port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vga_text_arbiter_if
  import vga_pkg::*;
#(
  parameter int ADDR_W = TEXT_ADDR_W,
  parameter int DATA_W = TEXT_DATA_W
);

  logic              vid_fetch;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdat;
  logic              vid_valid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdat;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdat;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] mem_rdat;

  modport slave (
    input  vid_fetch, vid_addr, host_req, host_we, host_addr, host_wdat, mem_rdat,
    output vid_rdat, vid_valid, host_ack, host_rdat, mem_addr, mem_we, mem_wdat
  );

  modport master (
    output vid_fetch, vid_addr, host_req, host_we, host_addr, host_wdat, mem_rdat,
    input  vid_rdat, vid_valid, host_ack, host_rdat, mem_addr, mem_we, mem_wdat
  );

endinterface

// File: rtl/vga_arb_host_fsm.sv
// Host transaction FSM for the text RAM arbiter.
// Latches one host request, waits for a cycle without a video fetch, issues
// it, and pulses host_ack. Host reads through the RAM exist only when
// VGA_ARB_HOST_READ_EN is defined; otherwise reads are acked with zero data.
//
// state   | meaning
// H_IDLE  | waiting for host_req, latches the request
// H_ISSUE | owns the RAM port unless a video fetch is present this cycle
// H_DATA  | RAM read data returning, captured into host_rdat
// H_ACK   | one-cycle completion pulse
module vga_arb_host_fsm
  import vga_pkg::*;
#(
  parameter int ADDR_W     = TEXT_ADDR_W,
  parameter int DATA_W     = TEXT_DATA_W,
  parameter int CHAR_COUNT = vga_pkg::CHAR_COUNT
) (
  input  logic              vga_clk,
  input  logic              vga_rst,
  input  logic              vid_fetch,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdat,
  input  logic [DATA_W-1:0] mem_rdat,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdat,
  output logic              host_mem_en,
  output logic              host_mem_we,
  output logic [ADDR_W-1:0] host_mem_addr,
  output logic [DATA_W-1:0] host_mem_wdat
);

  localparam logic [ADDR_W:0] CHAR_LIM = (ADDR_W+1)'(CHAR_COUNT);

  host_state_t       state, state_nxt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdat;
  logic              in_range;
  logic              issue_go;

  assign in_range = ({1'b0, lat_addr} < CHAR_LIM);
  assign issue_go = (state == H_ISSUE) && !vid_fetch;

  // State register
  always_ff @(posedge vga_clk) begin
    if (vga_rst) state <= H_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; out-of-range requests skip the RAM entirely
  always_comb begin
    state_nxt = state;
    unique case (state)
      H_IDLE:  if (host_req) state_nxt = H_ISSUE;
      H_ISSUE: if (!vid_fetch) begin
`ifdef VGA_ARB_HOST_READ_EN
        state_nxt = (lat_we || !in_range) ? H_ACK : H_DATA;
`else
        state_nxt = H_ACK;
`endif
      end
`ifdef VGA_ARB_HOST_READ_EN
      H_DATA:  state_nxt = H_ACK;
`endif
      H_ACK:   state_nxt = H_IDLE;
      default: state_nxt = H_IDLE;
    endcase
  end

  // Outputs: ack pulse and the RAM request handed to the port mux
  always_comb begin
    host_ack = (state == H_ACK);
`ifdef VGA_ARB_HOST_READ_EN
    host_mem_en = issue_go && in_range;
`else
    host_mem_en = issue_go && in_range && lat_we;
`endif
    host_mem_we = host_mem_en && lat_we;
  end

  assign host_mem_addr = lat_addr;
  assign host_mem_wdat = lat_wdat;

  // Request latch, loaded when a new transaction is accepted
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_wdat <= '0;
    end else if (state == H_IDLE && host_req) begin
      lat_we   <= host_we;
      lat_addr <= host_addr;
      lat_wdat <= host_wdat;
    end
  end

`ifdef VGA_ARB_HOST_READ_EN
  // Read data capture; out-of-range reads return zero
  always_ff @(posedge vga_clk) begin
    if (vga_rst)                    host_rdat <= '0;
    else if (state == H_DATA)       host_rdat <= mem_rdat;
    else if (issue_go && !in_range) host_rdat <= '0;
  end
`else
  logic unused_rdat;
  assign unused_rdat = ^mem_rdat;
  assign host_rdat   = '0;
`endif

endmodule

// File: rtl/vga_text_arbiter.sv
// Shares the single-port text RAM between video character fetch and a host
// port. Video always wins the port and returns data two cycles after the
// strobe; the host FSM fills the idle cycles. Host RAM reads are built only
// with VGA_ARB_HOST_READ_EN defined.
module vga_text_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = TEXT_ADDR_W,
  parameter int DATA_W     = TEXT_DATA_W,
  parameter int CHAR_COUNT = vga_pkg::CHAR_COUNT
) (
  input  logic               vga_clk,
  input  logic               vga_rst,
  vga_text_arbiter_if.slave  bus
);

  logic              host_mem_en;
  logic              host_mem_we;
  logic [ADDR_W-1:0] host_mem_addr;
  logic [DATA_W-1:0] host_mem_wdat;
  logic              tag_1;
  logic              tag_2;

  vga_arb_host_fsm #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CHAR_COUNT (CHAR_COUNT)
  ) u_host_fsm (
    .vga_clk       (vga_clk),
    .vga_rst       (vga_rst),
    .vid_fetch     (bus.vid_fetch),
    .host_req      (bus.host_req),
    .host_we       (bus.host_we),
    .host_addr     (bus.host_addr),
    .host_wdat     (bus.host_wdat),
    .mem_rdat      (bus.mem_rdat),
    .host_ack      (bus.host_ack),
    .host_rdat     (bus.host_rdat),
    .host_mem_en   (host_mem_en),
    .host_mem_we   (host_mem_we),
    .host_mem_addr (host_mem_addr),
    .host_mem_wdat (host_mem_wdat)
  );

  // RAM port mux: video first, then the host issue slot; a host op is never
  // driven while reset is held so a dropped write cannot land
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_we   = 1'b0;
    bus.mem_wdat = '0;
    if (bus.vid_fetch) begin
      bus.mem_addr = bus.vid_addr;
    end else if (host_mem_en && !vga_rst) begin
      bus.mem_addr = host_mem_addr;
      bus.mem_we   = host_mem_we;
      bus.mem_wdat = host_mem_wdat;
    end
  end

  // Video tag pipeline and data capture, one tag per in-flight fetch
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      tag_1        <= 1'b0;
      tag_2        <= 1'b0;
      bus.vid_rdat <= '0;
    end else begin
      tag_1 <= bus.vid_fetch;
      tag_2 <= tag_1;
      if (tag_1) bus.vid_rdat <= bus.mem_rdat;
    end
  end

  assign bus.vid_valid = tag_2;

endmodule

// File: tb/tb_vga_text_arbiter.sv
// Directed bench for vga_text_arbiter with a behavioural one-cycle text RAM.
// Expectations follow VGA_ARB_HOST_READ_EN the same way the design does.
module tb_vga_text_arbiter;

  logic vga_clk;
  logic vga_rst;
  int   total = 0;
  int   bad   = 0;
  int   we_cnt = 0;
  int   lat;
  int   wc0;

  logic [15:0] ram [0:2047];

  vga_text_arbiter_if #(.ADDR_W(11), .DATA_W(16)) bus ();

  vga_text_arbiter dut (
    .vga_clk (vga_clk),
    .vga_rst (vga_rst),
    .bus     (bus)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Text RAM: synchronous write, read data one cycle after the address
  always @(posedge vga_clk) begin
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdat;
    bus.mem_rdat <= ram[bus.mem_addr];
  end

  always @(negedge vga_clk) begin
    if (bus.mem_we === 1'b1) we_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a host transaction in the current cycle; lat = cycles to ack, -1 on timeout
  task automatic host_op(input logic we, input logic [10:0] addr,
                         input logic [15:0] wdat, output int lat_o);
    bus.host_req  = 1'b1;
    bus.host_we   = we;
    bus.host_addr = addr;
    bus.host_wdat = wdat;
    lat_o = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.host_ack === 1'b1) begin
        lat_o = i;
        break;
      end
    end
    bus.host_req = 1'b0;
  endtask

  initial begin
    vga_rst       = 1'b1;
    bus.vid_fetch = 1'b0;
    bus.vid_addr  = '0;
    bus.host_req  = 1'b0;
    bus.host_we   = 1'b0;
    bus.host_addr = '0;
    bus.host_wdat = '0;
    tick();
    tick();
    chk("rst_vid_rdat",  32'(bus.vid_rdat),  32'h0);
    chk("rst_vid_valid", 32'(bus.vid_valid), 32'h0);
    chk("rst_host_ack",  32'(bus.host_ack),  32'h0);
    chk("rst_host_rdat", 32'(bus.host_rdat), 32'h0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'h0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("rst_mem_wdat",  32'(bus.mem_wdat),  32'h0);
    vga_rst = 1'b0;
    tick();

    // Preload cells 0..2 through the host port
    host_op(1'b1, 11'd0, 16'h0741, lat); chk("pre0_lat", 32'(lat), 32'd2);
    tick();
    host_op(1'b1, 11'd1, 16'h0742, lat); chk("pre1_lat", 32'(lat), 32'd2);
    tick();
    host_op(1'b1, 11'd2, 16'h0743, lat); chk("pre2_lat", 32'(lat), 32'd2);
    tick();

    // Video only: strobes at 0, 8, 16 -> valid at 2, 10, 18
    for (int c = 0; c < 20; c++) begin
      tick();
      bus.vid_fetch = (c % 8 == 0);
      bus.vid_addr  = 11'(c / 8);
      #1;
      chk($sformatf("vid_valid_c%0d", c), 32'(bus.vid_valid),
          ((c % 8 == 2) && c <= 18) ? 32'h1 : 32'h0);
      if ((c % 8 == 2) && c <= 18)
        chk($sformatf("vid_rdat_c%0d", c), 32'(bus.vid_rdat), 32'h0741 + 32'(c / 8));
    end

    // Host write 5 then read 5, no video
    tick();
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'd5; bus.host_wdat = 16'hABCD;
    #1;
    chk("w5_ack_t0", 32'(bus.host_ack), 32'h0);
    tick();
    chk("w5_mem_we",   32'(bus.mem_we),   32'h1);
    chk("w5_mem_addr", 32'(bus.mem_addr), 32'd5);
    chk("w5_mem_wdat", 32'(bus.mem_wdat), 32'hABCD);
    chk("w5_ack_t1",   32'(bus.host_ack), 32'h0);
    tick();
    chk("w5_ack_t2", 32'(bus.host_ack), 32'h1);
    bus.host_req = 1'b0;
    tick();
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 11'd5;
    tick();
    chk("r5_mem_we", 32'(bus.mem_we), 32'h0);
`ifdef VGA_ARB_HOST_READ_EN
    chk("r5_mem_addr", 32'(bus.mem_addr), 32'd5);
    tick();
    chk("r5_ack_t2", 32'(bus.host_ack), 32'h0);
    tick();
    chk("r5_ack_t3", 32'(bus.host_ack),  32'h1);
    chk("r5_rdat",   32'(bus.host_rdat), 32'hABCD);
`else
    chk("r5_mem_addr", 32'(bus.mem_addr), 32'd0);
    tick();
    chk("r5_ack_t2", 32'(bus.host_ack),  32'h1);
    chk("r5_rdat",   32'(bus.host_rdat), 32'h0);
`endif
    bus.host_req = 1'b0;
    tick();

    // Video strobe collides with the host write issue cycle
    tick();
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'd7; bus.host_wdat = 16'h1234;
    #1;
    chk("st_ack_t0", 32'(bus.host_ack), 32'h0);
    tick();
    bus.vid_fetch = 1'b1; bus.vid_addr = 11'd1;
    #1;
    chk("st_mem_addr_vid", 32'(bus.mem_addr), 32'd1);
    chk("st_mem_we_vid",   32'(bus.mem_we),   32'h0);
    tick();
    bus.vid_fetch = 1'b0;
    #1;
    chk("st_mem_we_host",   32'(bus.mem_we),   32'h1);
    chk("st_mem_addr_host", 32'(bus.mem_addr), 32'd7);
    chk("st_mem_wdat_host", 32'(bus.mem_wdat), 32'h1234);
    chk("st_ack_t2",        32'(bus.host_ack), 32'h0);
    tick();
    chk("st_ack_t3",    32'(bus.host_ack),  32'h1);
    chk("st_vid_valid", 32'(bus.vid_valid), 32'h1);
    chk("st_vid_rdat",  32'(bus.vid_rdat),  32'h0742);
    bus.host_req = 1'b0;
    tick();

    // Fetch cell 7 by video to confirm the stalled write landed
    tick();
    bus.vid_fetch = 1'b1; bus.vid_addr = 11'd7;
    tick();
    bus.vid_fetch = 1'b0;
    tick();
    chk("st_cell7_valid", 32'(bus.vid_valid), 32'h1);
    chk("st_cell7_rdat",  32'(bus.vid_rdat),  32'h1234);

    // Back-to-back strobes
    tick();
    tick();
    bus.vid_fetch = 1'b1; bus.vid_addr = 11'd0;
    tick();
    bus.vid_addr = 11'd1;
    tick();
    bus.vid_fetch = 1'b0;
    #1;
    chk("b2b_valid0", 32'(bus.vid_valid), 32'h1);
    chk("b2b_rdat0",  32'(bus.vid_rdat),  32'h0741);
    tick();
    chk("b2b_valid1", 32'(bus.vid_valid), 32'h1);
    chk("b2b_rdat1",  32'(bus.vid_rdat),  32'h0742);
    tick();
    chk("b2b_valid2", 32'(bus.vid_valid), 32'h0);

    // Out-of-range host accesses
    wc0 = we_cnt;
    tick();
    host_op(1'b0, 11'd2000, 16'h0000, lat);
    chk("oor_rd_lat",  32'(lat),           32'd2);
    chk("oor_rd_rdat", 32'(bus.host_rdat), 32'h0);
    tick();
    host_op(1'b1, 11'd2000, 16'hFFFF, lat);
    chk("oor_wr_lat", 32'(lat), 32'd2);
    tick();
    chk("oor_no_we", 32'(we_cnt), 32'(wc0));

    // Reset while a write is pending in H_ISSUE
    wc0 = we_cnt;
    tick();
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'd9; bus.host_wdat = 16'h5555;
    tick();
    vga_rst = 1'b1; bus.vid_fetch = 1'b1; bus.vid_addr = 11'd2;
    #1;
    chk("mrst_mem_we", 32'(bus.mem_we), 32'h0);
    tick();
    vga_rst = 1'b0; bus.vid_fetch = 1'b0; bus.host_req = 1'b0;
    #1;
    chk("mrst_ack",       32'(bus.host_ack),  32'h0);
    chk("mrst_mem_we2",   32'(bus.mem_we),    32'h0);
    chk("mrst_mem_addr",  32'(bus.mem_addr),  32'h0);
    chk("mrst_mem_wdat",  32'(bus.mem_wdat),  32'h0);
    chk("mrst_vid_valid", 32'(bus.vid_valid), 32'h0);
    chk("mrst_vid_rdat",  32'(bus.vid_rdat),  32'h0);
    chk("mrst_host_rdat", 32'(bus.host_rdat), 32'h0);
    tick();
    chk("mrst_vid_valid2", 32'(bus.vid_valid), 32'h0);
    chk("mrst_ack2",       32'(bus.host_ack),  32'h0);
    tick();
    chk("mrst_ack3",   32'(bus.host_ack), 32'h0);
    chk("mrst_no_we",  32'(we_cnt),       32'(wc0));

    // Host read of cell 0
    tick();
    host_op(1'b0, 11'd0, 16'h0000, lat);
`ifdef VGA_ARB_HOST_READ_EN
    chk("r0_lat",  32'(lat),           32'd3);
    chk("r0_rdat", 32'(bus.host_rdat), 32'h0741);
`else
    chk("r0_lat",  32'(lat),           32'd2);
    chk("r0_rdat", 32'(bus.host_rdat), 32'h0);
`endif
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
